// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream handshake bundle feeding the loader
// Purpose: groups the valid/ready byte stream into one interface.
// Signals: in_valid (byte offered), in_data (stream byte), in_ready (sink can accept).
// Modports: master drives valid/data and samples ready; slave does the reverse.
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader streaming a big-endian image into IMEM
// Purpose: collects a 4-byte word count N, then N big-endian words, writing each
//   to consecutive IMEM word addresses; holds the CPU in reset until the image is
//   committed.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stream (slave)    in_valid / in_data / in_ready byte stream
//   reload            single-cycle restart request
//   imem_we/addr/wdata  IMEM write port (one-cycle strobe)
//   cpu_nrst          active-low processor reset
//   done, error       image loaded / header rejected
module imem_loader #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   imem_loader_if.slave        stream,
   input  logic                reload,
   output logic                imem_we,
   output logic [31:0]         imem_addr,
   output logic [31:0]         imem_wdata,
   output logic                cpu_nrst,
   output logic                done,
   output logic                error
);
   localparam int IW = $clog2(DEPTH_WORDS) + 1;

   typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

   state_t          state, state_next;
   logic [1:0]      byte_cnt;
   logic [IW-1:0]   word_idx;
   logic [IW-1:0]   n_words;
   logic [31:0]     shift;

   logic            accept;
   logic            last_byte;
   logic            hdr_bad;
   logic [31:0]     word;
   logic [IW-1:0]   idx_next;

   // Ready depends only on state and reset, never on in_valid.
   assign stream.in_ready = ((state == S_LEN) || (state == S_DATA)) && !rst;

   always_comb begin
      state_next = state;
      accept     = stream.in_valid && stream.in_ready;
      word       = {shift[23:0], stream.in_data};
      last_byte  = accept && (byte_cnt == 2'd3);
      hdr_bad    = (word == 32'd0) || (word > 32'(DEPTH_WORDS));
      idx_next   = word_idx + IW'(1);
      if (reload) begin
         state_next = S_LEN;
      end else begin
         case (state)
            S_LEN:   if (last_byte) state_next = hdr_bad ? S_ERR : S_DATA;
            S_DATA:  if (last_byte && (idx_next == n_words)) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_LEN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LEN;
         byte_cnt   <= 2'd0;
         word_idx   <= '0;
         n_words    <= '0;
         shift      <= 32'd0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'd0;
         cpu_nrst   <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state   <= state_next;
         imem_we <= 1'b0;
         if (reload) begin
            // Address and data of the last write are deliberately kept.
            byte_cnt <= 2'd0;
            word_idx <= '0;
            n_words  <= '0;
            shift    <= 32'd0;
            cpu_nrst <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
         end else begin
            if (accept) begin
               shift    <= word;
               byte_cnt <= byte_cnt + 2'd1;
            end
            if (last_byte && (state == S_LEN) && !hdr_bad)
               n_words <= word[IW-1:0];
            if (last_byte && (state == S_DATA)) begin
               imem_we    <= 1'b1;
               imem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
               imem_wdata <= word;
               word_idx   <= idx_next;
            end
            done  <= (state_next == S_DONE);
            error <= (state_next == S_ERR);
            // One edge behind done, so the final write lands before the CPU runs.
            cpu_nrst <= (state == S_DONE);
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst;
   logic reload0, reload1;
   logic we0, we1, nrst0, nrst1, done0, done1, err0, err1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   int total = 0;
   int bad   = 0;
   int wcnt0 = 0;

   always #5 clk = ~clk;

   imem_loader_if if0();
   imem_loader_if if1();

   imem_loader dut0 (
      .clk(clk), .rst(rst), .stream(if0), .reload(reload0),
      .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
      .cpu_nrst(nrst0), .done(done0), .error(err0)
   );

   imem_loader #(.DEPTH_WORDS(3), .BASE_ADDR(32'h0000_0100)) dut1 (
      .clk(clk), .rst(rst), .stream(if1), .reload(reload1),
      .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
      .cpu_nrst(nrst1), .done(done1), .error(err1)
   );

   always @(negedge clk) if (we0 === 1'b1) wcnt0++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic put0(input logic [7:0] b);
      if0.in_valid = 1'b1;
      if0.in_data  = b;
      tick();
   endtask

   task automatic put1(input logic [7:0] b);
      if1.in_valid = 1'b1;
      if1.in_data  = b;
      tick();
   endtask

   task automatic word0(input logic [31:0] w);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) put0(t[31-8*i -: 8]);
   endtask

   task automatic word1(input logic [31:0] w);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) put1(t[31-8*i -: 8]);
   endtask

   task automatic idle0();
      if0.in_valid = 1'b0;
      if0.in_data  = 8'h00;
   endtask

   task automatic reload_dut0();
      idle0();
      reload0 = 1'b1;
      tick();
      reload0 = 1'b0;
   endtask

   initial begin
      int w;
      rst = 1'b1; reload0 = 1'b0; reload1 = 1'b0;
      if0.in_valid = 1'b0; if0.in_data = 8'h00;
      if1.in_valid = 1'b0; if1.in_data = 8'h00;
      tick(); tick();
      // Reset state
      check("rst_ready", 32'(if0.in_ready), 32'd0);
      check("rst_we", 32'(we0), 32'd0);
      check("rst_addr", addr0, 32'h0);
      check("rst_addr1", addr1, 32'h100);
      check("rst_wdata", wdata0, 32'h0);
      check("rst_nrst", 32'(nrst0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(if0.in_ready), 32'd1);

      // 1: two-word image at full rate
      word0(32'h0000_0002);
      put0(8'h24); put0(8'h08); put0(8'h00);
      check("t1_no_early_we", 32'(we0), 32'd0);
      put0(8'h05);
      check("t1_we0", 32'(we0), 32'd1);
      check("t1_addr0", addr0, 32'h0);
      check("t1_data0", wdata0, 32'h2408_0005);
      check("t1_done_early", 32'(done0), 32'd0);
      put0(8'h00);
      check("t1_we_pulse", 32'(we0), 32'd0);
      put0(8'h00); put0(8'h00); put0(8'h0C);
      check("t1_we1", 32'(we0), 32'd1);
      check("t1_addr1", addr0, 32'h4);
      check("t1_data1", wdata0, 32'h0000_000C);
      check("t1_done", 32'(done0), 32'd1);
      check("t1_nrst_held", 32'(nrst0), 32'd0);
      check("t1_ready_low", 32'(if0.in_ready), 32'd0);
      idle0();
      tick();
      check("t1_nrst_rel", 32'(nrst0), 32'd1);
      check("t1_done_hold", 32'(done0), 32'd1);
      check("t1_wcnt", 32'(wcnt0), 32'd2);

      // 5: reload in S_DONE with a byte offered; byte must be dropped
      if0.in_valid = 1'b1; if0.in_data = 8'hAA;
      reload0 = 1'b1;
      tick();
      reload0 = 1'b0;
      check("t5_done", 32'(done0), 32'd0);
      check("t5_nrst", 32'(nrst0), 32'd0);
      check("t5_ready", 32'(if0.in_ready), 32'd1);
      check("t5_addr_hold", addr0, 32'h4);
      word0(32'h0000_0001);
      check("t5_hdr_ok", 32'(err0), 32'd0);
      check("t5_hdr_ready", 32'(if0.in_ready), 32'd1);
      word0(32'h1122_3344);
      check("t5_we", 32'(we0), 32'd1);
      check("t5_addr", addr0, 32'h0);
      check("t5_data", wdata0, 32'h1122_3344);
      check("t5_done2", 32'(done0), 32'd1);

      // 2: rejected headers (N=0, N=257), N=256 accepted
      reload_dut0();
      w = wcnt0;
      put0(8'h00); put0(8'h00); put0(8'h00);
      check("t2_err_early", 32'(err0), 32'd0);
      put0(8'h00);
      check("t2_err_zero", 32'(err0), 32'd1);
      check("t2_ready_zero", 32'(if0.in_ready), 32'd0);
      idle0();
      tick();
      check("t2_nrst_zero", 32'(nrst0), 32'd0);
      check("t2_err_hold", 32'(err0), 32'd1);
      check("t2_no_we", 32'(wcnt0), 32'(w));
      reload_dut0();
      check("t2_err_clr", 32'(err0), 32'd0);
      word0(32'h0000_0101);
      check("t2_err_big", 32'(err0), 32'd1);
      check("t2_ready_big", 32'(if0.in_ready), 32'd0);
      reload_dut0();
      word0(32'h0000_0100);
      check("t2_max_ok", 32'(err0), 32'd0);
      check("t2_max_ready", 32'(if0.in_ready), 32'd1);

      // 3: one-word image with in_valid toggling; FF offered while invalid
      reload_dut0();
      begin
         logic [63:0] img;
         img = 64'h0000_0001_DEAD_BEEF;
         for (int i = 0; i < 8; i++) begin
            put0(img[63-8*i -: 8]);
            if (i == 7) begin
               check("t3_we", 32'(we0), 32'd1);
               check("t3_addr", addr0, 32'h0);
               check("t3_data", wdata0, 32'hDEAD_BEEF);
               check("t3_done", 32'(done0), 32'd1);
            end
            if0.in_valid = 1'b0;
            if0.in_data  = 8'hFF;
            tick();
         end
      end
      check("t3_single_we", 32'(we0), 32'd0);

      // 4: rst after two of four words, then fresh one-word image
      reload_dut0();
      word0(32'h0000_0004);
      word0(32'hAAAA_0001);
      word0(32'hAAAA_0002);
      check("t4_addr_w2", addr0, 32'h4);
      put0(8'h12); put0(8'h34);
      rst = 1'b1;
      if0.in_valid = 1'b1; if0.in_data = 8'h77;
      tick();
      check("t4_ready_rst", 32'(if0.in_ready), 32'd0);
      check("t4_nrst", 32'(nrst0), 32'd0);
      check("t4_addr_rst", addr0, 32'h0);
      rst = 1'b0;
      word0(32'h0000_0001);
      word0(32'hCAFE_BABE);
      check("t4_we", 32'(we0), 32'd1);
      check("t4_addr", addr0, 32'h0);
      check("t4_data", wdata0, 32'hCAFE_BABE);
      check("t4_done", 32'(done0), 32'd1);

      // 6: BASE_ADDR=0x100, DEPTH_WORDS=3; N=4 rejected, N=3 loads
      idle0();
      word1(32'h0000_0004);
      check("t6_err_over", 32'(err1), 32'd1);
      if1.in_valid = 1'b0;
      reload1 = 1'b1;
      tick();
      reload1 = 1'b0;
      word1(32'h0000_0003);
      check("t6_hdr_ok", 32'(err1), 32'd0);
      word1(32'h0100_0001);
      check("t6_addr0", addr1, 32'h100);
      check("t6_data0", wdata1, 32'h0100_0001);
      check("t6_done0", 32'(done1), 32'd0);
      word1(32'h0200_0002);
      check("t6_addr1", addr1, 32'h104);
      check("t6_data1", wdata1, 32'h0200_0002);
      word1(32'h0300_0003);
      check("t6_we2", 32'(we1), 32'd1);
      check("t6_addr2", addr1, 32'h108);
      check("t6_data2", wdata1, 32'h0300_0003);
      check("t6_done2", 32'(done1), 32'd1);
      check("t6_nrst_held", 32'(nrst1), 32'd0);
      if1.in_valid = 1'b0;
      tick();
      check("t6_nrst_rel", 32'(nrst1), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
